// File: rtl/ofdm_pkg.sv
// Shared constants and read-side state encoding for the cyclic-prefix inserter.
package ofdm_pkg;

    localparam int N_FFT  = 64;
    localparam int CP_LEN = 16;
    localparam int DW     = 16;
    localparam int IDX_W  = $clog2(N_FFT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank simple dual-port symbol store, one write and one read port, 1-cycle synchronous read.
module ofdm_pingpong_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic                     wbank_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic                     rbank_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[{wbank_i, waddr_i}] <= wdata_i;
        end
    end

    // rdata_o holds its value while re_i is low, which the output stall relies on.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_o <= mem[{rbank_i, raddr_i}];
        end
    end

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Buffers whole OFDM symbols in a ping-pong RAM and replays each as CP tail + body
// through a registered valid/ready output; read address, RAM output and output register stall together.
module ofdm_cp_inserter
    import ofdm_pkg::*;
#(
    parameter int N_FFT  = ofdm_pkg::N_FFT,
    parameter int CP_LEN = ofdm_pkg::CP_LEN,
    parameter int DW     = ofdm_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data_i,
    input  logic [DW-1:0] in_data_q,
    input  logic          in_done,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data_i,
    output logic [DW-1:0] out_data_q,
    output logic          out_sym_start,
    output logic          overflow,
    output logic          frame_done
);

    localparam int            IW       = $clog2(N_FFT);
    localparam logic [IW-1:0] LAST     = IW'(N_FFT - 1);
    localparam logic [IW-1:0] CP_START = IW'(N_FFT - CP_LEN);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    logic            in_done_q;
    logic            frame_done_q, frame_done_d;

    rd_state_e       state_q;
    logic            rd_bank_q;
    logic [IW-1:0]   rd_idx_q;
    logic            rd_pend_q, pend_start_q, pend_last_q;
    logic            out_valid_q, out_start_q, out_last_q;
    logic [DW-1:0]   out_i_q, out_q_q;

    logic            adv, issue, issue_start, issue_last, wr_en, rd_free, pipe_empty;
    logic [2*DW-1:0] rd_data;

    assign adv         = en && (!out_valid_q || out_ready);
    assign issue       = adv && (state_q != ST_IDLE || full_q[rd_bank_q]);
    assign issue_start = (state_q != ST_BODY) && (rd_idx_q == CP_START);
    assign issue_last  = (state_q == ST_BODY) && (rd_idx_q == LAST);
    assign wr_en       = en && in_valid && !full_q[wr_bank_q];
    // rd_bank has already moved on by the time the last body sample is accepted.
    assign rd_free     = en && out_valid_q && out_ready && out_last_q;
    assign pipe_empty  = (state_q == ST_IDLE) && !rd_pend_q && !out_valid_q;

    ofdm_pingpong_ram #(.DEPTH(N_FFT), .WIDTH(2*DW)) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_idx_q),
        .wdata_i ({in_data_i, in_data_q}),
        .re_i    (issue),
        .rbank_i (rd_bank_q),
        .raddr_i (rd_idx_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        wr_idx_d     = wr_idx_q;
        overflow_d   = overflow_q;
        done_d       = done_q;
        frame_done_d = 1'b0;
        if (rd_free) begin
            full_d[~rd_bank_q] = 1'b0;
        end
        if (in_valid) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else if (wr_idx_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end else if (done_q) begin
            wr_idx_d = '0;
        end
        if (in_done && !in_done_q) begin
            done_d = 1'b1;
        end
        if (done_q && full_q == 2'b00 && wr_idx_q == '0 && pipe_empty) begin
            frame_done_d = 1'b1;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            in_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (en) begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            in_done_q    <= in_done;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_bank_q    <= 1'b0;
            rd_idx_q     <= CP_START;
            rd_pend_q    <= 1'b0;
            pend_start_q <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_start_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
        end else if (adv) begin
            rd_pend_q    <= issue;
            pend_start_q <= issue && issue_start;
            pend_last_q  <= issue && issue_last;
            out_valid_q  <= rd_pend_q;
            out_start_q  <= rd_pend_q && pend_start_q;
            out_last_q   <= rd_pend_q && pend_last_q;
            if (rd_pend_q) begin
                out_i_q <= rd_data[2*DW-1:DW];
                out_q_q <= rd_data[DW-1:0];
            end
            if (issue) begin
                case (state_q)
                    ST_BODY: begin
                        if (rd_idx_q == LAST) begin
                            rd_bank_q <= ~rd_bank_q;
                            rd_idx_q  <= CP_START;
                            state_q   <= full_q[~rd_bank_q] ? ST_CP : ST_IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                    default: begin
                        if (rd_idx_q == LAST) begin
                            state_q  <= ST_BODY;
                            rd_idx_q <= '0;
                        end else begin
                            state_q  <= ST_CP;
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data_i    = out_i_q;
    assign out_data_q    = out_q_q;
    assign out_sym_start = out_start_q;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Directed scenarios with random data/backpressure, scored against a cyclic-prefix reference queue.
module tb_ofdm_cp_inserter;

    localparam int N  = 64;
    localparam int CP = 16;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data_i = '0;
    logic [W-1:0] in_data_q = '0;
    logic         in_done = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] out_data_i;
    logic [W-1:0] out_data_q;
    logic         out_sym_start;
    logic         overflow;
    logic         frame_done;

    ofdm_cp_inserter dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .in_valid      (in_valid),
        .in_data_i     (in_data_i),
        .in_data_q     (in_data_q),
        .in_done       (in_done),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data_i    (out_data_i),
        .out_data_q    (out_data_q),
        .out_sym_start (out_sym_start),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    logic [2*W:0] got_q [$];
    logic [2*W:0] exp_q [$];
    int           xfer_q [$];
    int           fd_q [$];
    int           first_vld = -1;
    logic [W-1:0] sym_i [N];
    logic [W-1:0] sym_q [N];
    bit           rnd_rdy = 1'b0;
    bit           stall_prev = 1'b0;
    logic [2*W+1:0] stall_val = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Outputs sampled mid-cycle; a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", 64'({out_valid, out_sym_start, out_data_i, out_data_q}), 64'(stall_val));
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready && en) begin
                got_q.push_back({out_sym_start, out_data_i, out_data_q});
                xfer_q.push_back(cyc);
            end
            if (frame_done) fd_q.push_back(cyc);
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_valid, out_sym_start, out_data_i, out_data_q};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] di, input logic [W-1:0] dq);
        step();
        in_valid  = 1'b1;
        in_data_i = di;
        in_data_q = dq;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic fill_ramp(input int base, input bit negq);
        for (int k = 0; k < N; k++) begin
            sym_i[k] = 16'(base + k);
            sym_q[k] = negq ? 16'(-(base + k)) : 16'($urandom);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++) begin
            sym_i[k] = 16'($urandom);
            sym_q[k] = 16'($urandom);
        end
    endtask

    // Expected output: sample k of the emitted symbol is input sample (k - CP) mod N.
    task automatic model_symbol();
        for (int k = 0; k < N + CP; k++) begin
            int src = (k + N - CP) % N;
            exp_q.push_back({k == 0, sym_i[src], sym_q[src]});
        end
    endtask

    task automatic send_symbol(input int gap_every, input int gap_len);
        for (int k = 0; k < N; k++) begin
            send(sym_i[k], sym_q[k]);
            if (gap_every > 0 && (k + 1) % gap_every == 0) idle(gap_len);
        end
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int b = 0;
        while (got_q.size() < n && b < budget) begin
            step();
            b++;
        end
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s[%0d]", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    endtask

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        xfer_q.delete();
        fd_q.delete();
        first_vld = -1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        idle(2);
        reset = 1'b0;
        clear();
    endtask

    initial begin
        int last_in;
        int fd0;
        int gap;

        // Reset state
        idle(2);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_data_i", 64'(out_data_i), 64'(0));
        chk("rst_data_q", 64'(out_data_q), 64'(0));
        chk("rst_sym_start", 64'(out_sym_start), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        do_reset();

        // Single ramp symbol, sink always ready
        fill_ramp(0, 1'b1);
        model_symbol();
        send_symbol(0, 0);
        idle(1);
        last_in = cyc;
        wait_outputs(N + CP, 200);
        idle(20);
        chk("latency", 64'(first_vld - last_in), 64'(2));
        compare_stream("single");

        // Two ramp symbols with input gaps
        do_reset();
        fill_ramp(0, 1'b0);
        model_symbol();
        send_symbol(16, 5);
        fill_ramp(100, 1'b0);
        model_symbol();
        send_symbol(16, 5);
        idle(1);
        wait_outputs(2 * (N + CP), 400);
        idle(20);
        compare_stream("gapped");
        chk("gapped_overflow", 64'(overflow), 64'(0));

        // Random backpressure
        do_reset();
        rnd_rdy = 1'b1;
        fill_ramp(0, 1'b1);
        model_symbol();
        send_symbol(0, 0);
        idle(1);
        wait_outputs(N + CP, 600);
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        idle(20);
        compare_stream("backpressure");

        // Overflow with a stalled sink: only two banks' worth survives
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            fill_rand();
            if (s < 2) model_symbol();
            for (int k = 0; k < N; k++) begin
                if (s == 2 && k == 1) chk("ovf_before_128", 64'(overflow), 64'(0));
                if (s == 2 && k == 2) chk("ovf_at_128", 64'(overflow), 64'(1));
                send(sym_i[k], sym_q[k]);
            end
        end
        idle(1);
        chk("ovf_sticky", 64'(overflow), 64'(1));
        out_ready = 1'b1;
        wait_outputs(2 * (N + CP), 400);
        idle(50);
        compare_stream("overflow");
        gap = (xfer_q.size() > N + CP) ? xfer_q[N + CP] - xfer_q[N + CP - 1] : -1;
        chk("back_to_back", 64'(gap), 64'(1));
        chk("ovf_still", 64'(overflow), 64'(1));

        // Frame end after three whole symbols, then again with a trailing partial symbol
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int s = 0; s < 3; s++) begin
                fill_rand();
                model_symbol();
                send_symbol(16, 5);
            end
            if (pass == 1) for (int k = 0; k < 30; k++) send(16'($urandom), 16'($urandom));
            idle(1);
            in_done = 1'b1;
            step();
            in_done = 1'b0;
            wait_outputs(3 * (N + CP), 800);
            idle(150);
            compare_stream($sformatf("frame%0d", pass));
            chk($sformatf("frame%0d_fd_count", pass), 64'(fd_q.size()), 64'(1));
            fd0 = (fd_q.size() > 0 && xfer_q.size() > 0) ? fd_q[0] - xfer_q[xfer_q.size() - 1] : -1;
            chk($sformatf("frame%0d_fd_timing", pass), 64'(fd0), 64'(2));
            chk($sformatf("frame%0d_overflow", pass), 64'(overflow), 64'(0));
        end
        // Discarded partial must not leak into the next symbol
        clear();
        fill_rand();
        model_symbol();
        send_symbol(0, 0);
        idle(1);
        wait_outputs(N + CP, 200);
        idle(20);
        compare_stream("after_flush");

        // Asynchronous reset in the body of a symbol
        do_reset();
        fill_rand();
        send_symbol(0, 0);
        idle(1);
        wait_outputs(40, 200);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_data_i", 64'(out_data_i), 64'(0));
        chk("midrst_data_q", 64'(out_data_q), 64'(0));
        chk("midrst_sym_start", 64'(out_sym_start), 64'(0));
        step();
        reset = 1'b0;
        clear();
        idle(10);
        chk("midrst_quiet", 64'(got_q.size()), 64'(0));
        fill_rand();
        model_symbol();
        send_symbol(0, 0);
        idle(1);
        wait_outputs(N + CP, 200);
        idle(100);
        compare_stream("post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
